// File: rtl/marker_centroid_tracker.sv
// marker_centroid_tracker
//   Accumulates the coordinates of colour-matched camera pixels over a frame and
//   divides the sums by the pixel count to produce the marker centroid. The
//   matched-pixel count doubles as a depth proxy (bigger blob = closer).
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous, active-high reset
//   x_in, y_in     coordinates of the current camera pixel
//   valid_in       x_in/y_in/mask_in valid this cycle
//   mask_in        pixel matches the marker colour
//   frame_done_in  one-cycle pulse at end of frame
//   x_out, y_out   centroid (floor of sum / count)
//   z_out          matched-pixel count, saturated at 16383
//   found_out      last completed frame had count >= MIN_PIXELS
//   valid_out      one-cycle pulse when outputs are updated
//   busy_out       divider running
//   overrun_out    one-cycle pulse when a frame was dropped (divider busy)
module marker_centroid_tracker #(
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        frame_done_in,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic [13:0] z_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        overrun_out
);

    localparam int REM_W  = ACC_W + 1;
    localparam int STEP_W = $clog2(ACC_W) + 1;
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_W - 1);
    localparam logic [CNT_W-1:0]  Z_MAX     = CNT_W'(16383);

    typedef enum logic [1:0] {ST_ACCUM, ST_DIVIDE, ST_PUBLISH} state_e;

    state_e state_q, state_d;

    logic [ACC_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  qx_q, qx_d, qy_q, qy_d;
    logic [REM_W-1:0]  rx_q, rx_d, ry_q, ry_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic              found_lat_q, found_lat_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [11:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic [13:0] z_out_q, z_out_d;
    logic        found_out_q, found_out_d;
    logic        valid_out_q, valid_out_d;
    logic        overrun_out_q, overrun_out_d;

    logic             hit;
    logic [ACC_W-1:0] sum_x_upd, sum_y_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             meets_min;
    logic [REM_W-1:0] divisor, rx_sh, ry_sh;

    // Running sums including this cycle's pixel, so a pixel coinciding with
    // frame_done_in lands in the closing frame.
    always_comb begin
        hit       = valid_in & mask_in;
        sum_x_upd = sum_x_q + (hit ? ACC_W'(x_in) : '0);
        sum_y_upd = sum_y_q + (hit ? ACC_W'(y_in) : '0);
        cnt_upd   = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        meets_min = (cnt_upd >= MIN_CNT);
        // Accumulators restart on every frame boundary, including dropped frames.
        sum_x_d   = frame_done_in ? '0 : sum_x_upd;
        sum_y_d   = frame_done_in ? '0 : sum_y_upd;
        cnt_d     = frame_done_in ? '0 : cnt_upd;
    end

    // State register (all state flops)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_ACCUM;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            cnt_q         <= '0;
            qx_q          <= '0;
            qy_q          <= '0;
            rx_q          <= '0;
            ry_q          <= '0;
            div_q         <= '0;
            found_lat_q   <= 1'b0;
            step_q        <= '0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            z_out_q       <= '0;
            found_out_q   <= 1'b0;
            valid_out_q   <= 1'b0;
            overrun_out_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            cnt_q         <= cnt_d;
            qx_q          <= qx_d;
            qy_q          <= qy_d;
            rx_q          <= rx_d;
            ry_q          <= ry_d;
            div_q         <= div_d;
            found_lat_q   <= found_lat_d;
            step_q        <= step_d;
            x_out_q       <= x_out_d;
            y_out_q       <= y_out_d;
            z_out_q       <= z_out_d;
            found_out_q   <= found_out_d;
            valid_out_q   <= valid_out_d;
            overrun_out_q <= overrun_out_d;
        end
    end

    // Next-state and divider datapath
    always_comb begin
        state_d     = state_q;
        qx_d        = qx_q;
        qy_d        = qy_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        div_d       = div_q;
        found_lat_d = found_lat_q;
        step_d      = step_q;

        divisor = REM_W'(div_q);
        // Restoring step: the quotient register starts as the dividend and
        // shifts its MSB into the remainder while quotient bits shift in at the LSB.
        rx_sh   = {rx_q[ACC_W-1:0], qx_q[ACC_W-1]};
        ry_sh   = {ry_q[ACC_W-1:0], qy_q[ACC_W-1]};

        case (state_q)
            ST_ACCUM: begin
                if (frame_done_in) begin
                    qx_d        = sum_x_upd;
                    qy_d        = sum_y_upd;
                    rx_d        = '0;
                    ry_d        = '0;
                    div_d       = cnt_upd;
                    found_lat_d = meets_min;
                    step_d      = '0;
                    state_d     = meets_min ? ST_DIVIDE : ST_PUBLISH;
                end
            end
            ST_DIVIDE: begin
                if (rx_sh >= divisor) begin
                    rx_d = rx_sh - divisor;
                    qx_d = {qx_q[ACC_W-2:0], 1'b1};
                end else begin
                    rx_d = rx_sh;
                    qx_d = {qx_q[ACC_W-2:0], 1'b0};
                end
                if (ry_sh >= divisor) begin
                    ry_d = ry_sh - divisor;
                    qy_d = {qy_q[ACC_W-2:0], 1'b1};
                end else begin
                    ry_d = ry_sh;
                    qy_d = {qy_q[ACC_W-2:0], 1'b0};
                end
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Outputs
    always_comb begin
        x_out_d       = x_out_q;
        y_out_d       = y_out_q;
        z_out_d       = z_out_q;
        found_out_d   = found_out_q;
        valid_out_d   = 1'b0;
        overrun_out_d = frame_done_in && (state_q != ST_ACCUM);
        busy_out      = (state_q == ST_DIVIDE);

        if (state_q == ST_PUBLISH) begin
            valid_out_d = 1'b1;
            found_out_d = found_lat_q;
            z_out_d     = (div_q > Z_MAX) ? 14'h3FFF : 14'(div_q);
            if (found_lat_q) begin
                x_out_d = 12'(qx_q);
                y_out_d = 12'(qy_q);
            end
        end
    end

    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign z_out       = z_out_q;
    assign found_out   = found_out_q;
    assign valid_out   = valid_out_q;
    assign overrun_out = overrun_out_q;

endmodule

// File: tb/tb_marker_centroid_tracker.sv
// Testbench for marker_centroid_tracker: a default instance (MIN_PIXELS=16)
// and a MIN_PIXELS=1 instance share the same pixel stream. Expected results
// come from a per-frame sum/count model using plain integer arithmetic.
module tb_marker_centroid_tracker;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        mask_in = 1'b0;
    logic        frame_done_in = 1'b0;

    logic [11:0] x_out, y_out, x1_out, y1_out;
    logic [13:0] z_out, z1_out;
    logic        found_out, valid_out, busy_out, overrun_out;
    logic        found1_out, valid1_out, busy1_out, overrun1_out;

    marker_centroid_tracker dut (
        .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .mask_in(mask_in), .frame_done_in(frame_done_in),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .found_out(found_out),
        .valid_out(valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
    );

    marker_centroid_tracker #(.MIN_PIXELS(1)) dut1 (
        .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .mask_in(mask_in), .frame_done_in(frame_done_in),
        .x_out(x1_out), .y_out(y1_out), .z_out(z1_out), .found_out(found1_out),
        .valid_out(valid1_out), .busy_out(busy1_out), .overrun_out(overrun1_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: running frame totals, last closed frame, held centroid
    longint m_sx, m_sy, e_sx, e_sy;
    int     m_n, e_n;
    int     h_x, h_y;

    function automatic int exp_z();
        return (e_n > 16383) ? 16383 : e_n;
    endfunction

    function automatic bit exp_found();
        return e_n >= 16;
    endfunction

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_n = 0;
        h_x = 0; h_y = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix_raw(input int x, input int y, input bit v, input bit m);
        x_in = 11'(x); y_in = 10'(y); valid_in = v; mask_in = m;
        step();
        valid_in = 1'b0; mask_in = 1'b0;
        if (v && m) begin
            m_sx += x; m_sy += y; m_n++;
        end
    endtask

    task automatic pix(input int x, input int y);
        pix_raw(x, y, 1'b1, 1'b1);
    endtask

    // drop=1: frame is discarded by the DUT (overrun), totals simply restart
    task automatic close_frame(input bit drop, input bit pv, input int px, input int py);
        frame_done_in = 1'b1;
        x_in = 11'(px); y_in = 10'(py); valid_in = pv; mask_in = pv;
        step();
        frame_done_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
        if (pv) begin
            m_sx += px; m_sy += py; m_n++;
        end
        if (!drop) begin
            e_sx = m_sx; e_sy = m_sy; e_n = m_n;
            if (exp_found()) begin
                h_x = int'(e_sx / e_n);
                h_y = int'(e_sy / e_n);
            end
        end
        m_sx = 0; m_sy = 0; m_n = 0;
    endtask

    // Cycles until dut.valid_out (-1 on timeout); optional random pixels fed meanwhile
    task automatic wait_valid(input bit feed, output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (feed) pix($urandom_range(0, 1023), $urandom_range(0, 767));
            else step();
            if (valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle(2);
        checks++; if ({x_out, y_out, z_out, found_out, valid_out, busy_out, overrun_out} !== '0) begin
            errors++; $display("FAIL reset dut: outputs=%h required 0", {x_out, y_out, z_out, found_out, valid_out, busy_out, overrun_out});
        end
        checks++; if ({x1_out, y1_out, z1_out, found1_out, valid1_out, busy1_out, overrun1_out} !== '0) begin
            errors++; $display("FAIL reset dut1: outputs=%h required 0", {x1_out, y1_out, z1_out, found1_out, valid1_out, busy1_out, overrun1_out});
        end
        rst_in = 1'b0;
        model_clear();
    endtask

    task automatic test_block();
        int lat;
        for (int y = 200; y <= 209; y++)
            for (int x = 100; x <= 109; x++)
                if (!(x == 109 && y == 209)) pix(x, y);
        // last pixel arrives together with frame_done
        close_frame(1'b0, 1'b1, 109, 209);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL block busy: got %b required 1", busy_out); end
        wait_valid(1'b0, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL block latency: got %0d required 33", lat); end
        checks++; if (x_out !== 12'(h_x) || h_x != 104) begin errors++; $display("FAIL block x: got %0d required 104", x_out); end
        checks++; if (y_out !== 12'(h_y) || h_y != 204) begin errors++; $display("FAIL block y: got %0d required 204", y_out); end
        checks++; if (z_out !== 14'd100) begin errors++; $display("FAIL block z: got %0d required 100", z_out); end
        checks++; if (found_out !== 1'b1) begin errors++; $display("FAIL block found: got %b required 1", found_out); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL block valid pulse: got %b required 0", valid_out); end
    endtask

    task automatic test_empty();
        int lat;
        close_frame(1'b0, 1'b0, 0, 0);
        wait_valid(1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL empty latency: got %0d required 1", lat); end
        checks++; if (found_out !== 1'b0 || z_out !== 14'd0) begin errors++; $display("FAIL empty found/z: got %b/%0d required 0/0", found_out, z_out); end
        checks++; if (x_out !== 12'd104 || y_out !== 12'd204) begin errors++; $display("FAIL empty hold xy: got %0d,%0d required 104,204", x_out, y_out); end
    endtask

    task automatic test_fifteen();
        int lat;
        for (int i = 0; i < 15; i++) pix(300 + i, 50);
        pix_raw(5, 5, 1'b0, 1'b1);   // mask without valid is ignored
        pix_raw(6, 6, 1'b1, 1'b0);   // valid without mask is ignored
        close_frame(1'b0, 1'b0, 0, 0);
        wait_valid(1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL fifteen latency: got %0d required 1", lat); end
        checks++; if (found_out !== 1'b0 || z_out !== 14'd15) begin errors++; $display("FAIL fifteen found/z: got %b/%0d required 0/15", found_out, z_out); end
        checks++; if (x_out !== 12'(h_x) || y_out !== 12'(h_y)) begin errors++; $display("FAIL fifteen hold xy: got %0d,%0d required %0d,%0d", x_out, y_out, h_x, h_y); end
        idle(40);
    endtask

    task automatic test_corner();
        int lat, lat1;
        pix(1023, 767);
        close_frame(1'b0, 1'b0, 0, 0);
        lat1 = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (valid1_out) begin lat1 = k; break; end
        end
        checks++; if (lat1 != 33) begin errors++; $display("FAIL corner latency1: got %0d required 33", lat1); end
        checks++; if (x1_out !== 12'd1023 || y1_out !== 12'd767 || z1_out !== 14'd1 || found1_out !== 1'b1) begin
            errors++; $display("FAIL corner dut1: got x=%0d y=%0d z=%0d f=%b required 1023 767 1 1", x1_out, y1_out, z1_out, found1_out);
        end
        checks++; if (found_out !== 1'b0 || z_out !== 14'd1 || x_out !== 12'(h_x)) begin
            errors++; $display("FAIL corner dut: got f=%b z=%0d x=%0d required 0 1 %0d", found_out, z_out, x_out, h_x);
        end
        lat = 0;
    endtask

    task automatic test_saturate();
        int lat;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 1024; x++) pix(x, y);
        close_frame(1'b0, 1'b0, 0, 0);
        wait_valid(1'b0, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL saturate latency: got %0d required 33", lat); end
        checks++; if (x_out !== 12'(h_x) || y_out !== 12'(h_y)) begin errors++; $display("FAIL saturate xy: got %0d,%0d required %0d,%0d", x_out, y_out, h_x, h_y); end
        checks++; if (z_out !== 14'd16383 || found_out !== 1'b1) begin errors++; $display("FAIL saturate z/found: got %0d/%b required 16383/1", z_out, found_out); end
    endtask

    task automatic test_random();
        int lat, x0, y0, w, h;
        for (int f = 0; f < 8; f++) begin
            x0 = $urandom_range(0, 1000); y0 = $urandom_range(0, 750);
            w = $urandom_range(1, 12); h = $urandom_range(1, 12);
            for (int y = y0; y < y0 + h; y++)
                for (int x = x0; x < x0 + w; x++)
                    pix_raw(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
            close_frame(1'b0, 1'b0, 0, 0);
            checks++; if (x_out !== 12'(h_x) && exp_found()) begin
                // outputs must not move before valid_out
            end
            wait_valid(1'b0, lat);
            checks++; if (lat != (exp_found() ? 33 : 1)) begin errors++; $display("FAIL random%0d latency: got %0d required %0d", f, lat, exp_found() ? 33 : 1); end
            checks++; if (x_out !== 12'(h_x) || y_out !== 12'(h_y)) begin errors++; $display("FAIL random%0d xy: got %0d,%0d required %0d,%0d", f, x_out, y_out, h_x, h_y); end
            checks++; if (z_out !== 14'(exp_z()) || found_out !== exp_found()) begin errors++; $display("FAIL random%0d z/found: got %0d/%b required %0d/%b", f, z_out, found_out, exp_z(), exp_found()); end
        end
    endtask

    task automatic test_overrun();
        int lat;
        for (int i = 0; i < 30; i++) pix(400 + (i % 6), 100 + (i / 6));
        close_frame(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) pix(10, 10);
        close_frame(1'b1, 1'b1, 11, 11);
        checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL overrun pulse: got %b required 1", overrun_out); end
        pix($urandom_range(0, 1023), $urandom_range(0, 767));
        checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL overrun width: got %b required 0", overrun_out); end
        wait_valid(1'b1, lat);
        checks++; if (lat != 27) begin errors++; $display("FAIL overrun latency: got %0d required 27", lat); end
        checks++; if (x_out !== 12'(h_x) || y_out !== 12'(h_y) || z_out !== 14'd30) begin
            errors++; $display("FAIL overrun first: got %0d,%0d,%0d required %0d,%0d,30", x_out, y_out, z_out, h_x, h_y);
        end
        for (int i = 0; i < 20; i++) pix($urandom_range(0, 1023), $urandom_range(0, 767));
        close_frame(1'b0, 1'b0, 0, 0);
        wait_valid(1'b0, lat);
        checks++; if (lat != 33 || x_out !== 12'(h_x) || y_out !== 12'(h_y) || z_out !== 14'(exp_z())) begin
            errors++; $display("FAIL overrun next: got lat=%0d %0d,%0d,%0d required 33 %0d,%0d,%0d", lat, x_out, y_out, z_out, h_x, h_y, exp_z());
        end
    endtask

    task automatic test_reset_mid_divide();
        int seen;
        for (int i = 0; i < 20; i++) pix(700 + i, 600);
        close_frame(1'b0, 1'b0, 0, 0);
        idle(10);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL middiv busy: got %b required 1", busy_out); end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        model_clear();
        checks++; if ({x_out, y_out, z_out, found_out, valid_out, busy_out, overrun_out} !== '0) begin
            errors++; $display("FAIL middiv outputs: got %h required 0", {x_out, y_out, z_out, found_out, valid_out, busy_out, overrun_out});
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (valid_out) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL middiv valid: got %0d pulses required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_block();
        test_empty();
        test_fifteen();
        test_corner();
        test_saturate();
        idle(40);
        test_random();
        test_overrun();
        test_reset_mid_divide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
